// File: rtl/mult_4_arbiter.sv
// rtl/mult_4_arbiter.sv - round-robin arbiter sharing one sequential mult_4 multiplier
//
// Grants one of NUM_REQ requesters at a time, captures its 4-bit operands,
// holds mul_init for INIT_CYCLES cycles, waits for mul_done (bounded by
// TIMEOUT cycles) and returns the 8-bit product tagged with the requester id.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous reset, active-low
//   req        per-requester request level
//   req_a      operand A, requester i at [4i+3:4i]
//   req_b      operand B, requester i at [4i+3:4i]
//   ack        one-cycle pulse, operands of requester i captured
//   rsp_valid  one-cycle pulse, rsp_pp/rsp_id/rsp_err valid
//   rsp_pp     product (0 on timeout)
//   rsp_id     requester owning the response
//   rsp_err    high with rsp_valid when the multiplier timed out
//   busy       high whenever the arbiter is not idle
//   mul_init   to multiplier init
//   mul_a      to multiplier A (stable from launch through wait)
//   mul_b      to multiplier B
//   mul_pp     from multiplier product
//   mul_done   from multiplier done

module mult_4_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_pp,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mul_init,
  output logic [3:0]           mul_a,
  output logic [3:0]           mul_b,
  input  logic [7:0]           mul_pp,
  input  logic                 mul_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [ID_W-1:0]     last_grant, last_grant_n;
  logic [ID_W-1:0]     gnt_id, gnt_id_n;
  logic [3:0]          init_cnt, init_cnt_n;
  logic [7:0]          wait_cnt, wait_cnt_n;

  logic [NUM_REQ-1:0]  ack_n;
  logic                rsp_valid_n;
  logic [7:0]          rsp_pp_n;
  logic [ID_W-1:0]     rsp_id_n;
  logic                rsp_err_n;
  logic                busy_n;
  logic                mul_init_n;
  logic [3:0]          mul_a_n;
  logic [3:0]          mul_b_n;

  logic                pick_found;
  logic [ID_W-1:0]     pick_id;

  // Round-robin pick: first set request bit starting just after last_grant.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_found && req[(int'(last_grant) + k) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    gnt_id_n     = gnt_id;
    init_cnt_n   = init_cnt;
    wait_cnt_n   = wait_cnt;
    ack_n        = '0;
    rsp_valid_n  = 1'b0;
    rsp_pp_n     = rsp_pp;
    rsp_id_n     = rsp_id;
    rsp_err_n    = rsp_err;
    busy_n       = busy;
    mul_init_n   = mul_init;
    mul_a_n      = mul_a;
    mul_b_n      = mul_b;

    case (state)
      S_IDLE: begin
        if (pick_found) begin
          gnt_id_n       = pick_id;
          last_grant_n   = pick_id;
          mul_a_n        = req_a[4*int'(pick_id) +: 4];
          mul_b_n        = req_b[4*int'(pick_id) +: 4];
          // ack and mul_init land together in the first LAUNCH cycle
          ack_n[pick_id] = 1'b1;
          mul_init_n     = 1'b1;
          busy_n         = 1'b1;
          init_cnt_n     = '0;
          state_n        = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (init_cnt == 4'(INIT_CYCLES - 1)) begin
          mul_init_n = 1'b0;
          wait_cnt_n = '0;
          state_n    = S_WAIT;
        end else begin
          init_cnt_n = init_cnt + 4'd1;
        end
      end
      S_WAIT: begin
        // done is checked before the timeout so a done on the last cycle wins
        if (mul_done) begin
          rsp_pp_n    = mul_pp;
          rsp_err_n   = 1'b0;
          rsp_id_n    = gnt_id;
          rsp_valid_n = 1'b1;
          state_n     = S_DELIVER;
        end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
          rsp_pp_n    = 8'd0;
          rsp_err_n   = 1'b1;
          rsp_id_n    = gnt_id;
          rsp_valid_n = 1'b1;
          state_n     = S_DELIVER;
        end else begin
          wait_cnt_n = wait_cnt + 8'd1;
        end
      end
      S_DELIVER: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      gnt_id     <= '0;
      init_cnt   <= '0;
      wait_cnt   <= '0;
      ack        <= '0;
      rsp_valid  <= 1'b0;
      rsp_pp     <= '0;
      rsp_id     <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      mul_init   <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      gnt_id     <= gnt_id_n;
      init_cnt   <= init_cnt_n;
      wait_cnt   <= wait_cnt_n;
      ack        <= ack_n;
      rsp_valid  <= rsp_valid_n;
      rsp_pp     <= rsp_pp_n;
      rsp_id     <= rsp_id_n;
      rsp_err    <= rsp_err_n;
      busy       <= busy_n;
      mul_init   <= mul_init_n;
      mul_a      <= mul_a_n;
      mul_b      <= mul_b_n;
    end
  end

endmodule

// File: tb/tb_mult_4_arbiter.sv
// tb/tb_mult_4_arbiter.sv - scoreboard bench for mult_4_arbiter with a behavioural multiplier

module tb_mult_4_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  ack;
  logic        rsp_valid;
  logic [7:0]  rsp_pp;
  logic [1:0]  rsp_id;
  logic        rsp_err;
  logic        busy;
  logic        mul_init;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_pp = '0;
  logic        mul_done = 1'b0;

  always #5 clk = ~clk;

  mult_4_arbiter #(.NUM_REQ(4), .ID_W(2), .INIT_CYCLES(2), .TIMEOUT(31)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_pp(rsp_pp), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .busy(busy), .mul_init(mul_init), .mul_a(mul_a),
    .mul_b(mul_b), .mul_pp(mul_pp), .mul_done(mul_done)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] pp;
    logic [1:0] id;
    logic       err;
    int         wcyc;
  } rsp_t;

  rsp_t exp_rsp_q[$];
  int   exp_ack_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural multiplier: product appears as a one-cycle done pulse
  // mdl_delay cycles after init drops; mdl_en=0 models a hung unit.
  int         mdl_delay = 3;
  bit         mdl_en = 1'b1;
  bit         pending = 1'b0;
  int         mcnt = 0;
  logic [7:0] prod = '0;

  always @(negedge clk) begin
    if (!rst || !mdl_en) begin
      pending  = 1'b0;
      mul_done = 1'b0;
    end else if (mul_init) begin
      pending  = 1'b1;
      mcnt     = mdl_delay;
      prod     = mul_a * mul_b;
      mul_done = 1'b0;
    end else if (pending) begin
      if (mcnt == 0) begin
        mul_done = 1'b1;
        mul_pp   = prod;
        pending  = 1'b0;
      end else begin
        mcnt--;
        mul_done = 1'b0;
      end
    end else begin
      mul_done = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every ack and response.
  bit   in_flight = 1'b0;
  bit   prev_init = 1'b0;
  int   icnt = 0;
  int   wcnt = 0;
  int   mon_id;
  rsp_t mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      in_flight = 1'b0;
      prev_init = 1'b0;
      icnt      = 0;
      wcnt      = 0;
    end else begin
      if (ack != 4'd0) begin
        chk("ack_while_busy", 32'(in_flight), 32'd0);
        if (exp_ack_q.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          mon_id = exp_ack_q.pop_front();
          chk("ack_onehot", 32'(ack), 32'(1 << mon_id));
        end
        in_flight = 1'b1;
      end
      if (mul_init) begin
        icnt++;
      end else if (prev_init) begin
        chk("init_width", 32'(icnt), 32'd2);
        icnt = 0;
      end
      if (rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          mon_e = exp_rsp_q.pop_front();
          chk("rsp_pp", 32'(rsp_pp), 32'(mon_e.pp));
          chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
          if (mon_e.wcyc > 0) chk("wait_cycles", 32'(wcnt), 32'(mon_e.wcyc));
        end
        in_flight = 1'b0;
        wcnt      = 0;
      end else if (prev_init && !mul_init) begin
        wcnt = 1;
      end else if (wcnt != 0) begin
        wcnt++;
      end
      prev_init = mul_init;
    end
  end

  task automatic expect_op(input int id, input logic [7:0] pp, input logic err, input int wc);
    rsp_t e;
    e.pp = pp; e.id = 2'(id); e.err = err; e.wcyc = wc;
    exp_ack_q.push_back(id);
    exp_rsp_q.push_back(e);
  endtask

  task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b);
    req_a[4*id +: 4] = a;
    req_b[4*id +: 4] = b;
    req[id] = 1'b1;
  endtask

  // Requester side of the handshake: drop req for whoever gets acked.
  task automatic wait_ack_drop();
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ack != 4'd0) begin
        req = req & ~ack;
        got = 1'b1;
      end
    end
    chk("ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic wait_idle();
    bit done_ok = 1'b0;
    for (int i = 0; i < 400 && !done_ok; i++) begin
      @(negedge clk);
      if (exp_rsp_q.size() == 0 && !busy) done_ok = 1'b1;
    end
    chk("drain", 32'(exp_rsp_q.size()), 32'd0);
  endtask

  task automatic wait_init_low();
    int n = 0;
    @(negedge clk);
    while (mul_init && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("init_fall_timeout", 32'(mul_init), 32'd0);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_mul_init", 32'(mul_init), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1;

    // single request, maximum operands
    expect_op(0, 8'd225, 1'b0, 0);
    set_req(0, 4'hF, 4'hF);
    wait_ack_drop();
    wait_idle();

    // from reset, all four request: served in id order 0..3
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    expect_op(0, 8'd3, 1'b0, 0);
    expect_op(1, 8'd6, 1'b0, 0);
    expect_op(2, 8'd9, 1'b0, 0);
    expect_op(3, 8'd12, 1'b0, 0);
    for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 4'd3);
    for (int i = 0; i < 4; i++) wait_ack_drop();
    wait_idle();

    // after grant to 2, requesters 1 and 3 pending: 3 goes before 1
    expect_op(2, 8'd14, 1'b0, 0);
    expect_op(3, 8'd81, 1'b0, 0);
    expect_op(1, 8'd12, 1'b0, 0);
    set_req(2, 4'd2, 4'd7);
    wait_ack_drop();
    set_req(1, 4'd3, 4'd4);
    set_req(3, 4'd9, 4'd9);
    wait_ack_drop();
    wait_ack_drop();
    wait_idle();

    // hung multiplier: error response after 31 WAIT cycles, then normal service
    mdl_en = 1'b0;
    expect_op(2, 8'd0, 1'b1, 31);
    set_req(2, 4'd5, 4'd5);
    wait_ack_drop();
    wait_idle();
    mdl_en = 1'b1;
    expect_op(2, 8'd25, 1'b0, 0);
    set_req(2, 4'd5, 4'd5);
    wait_ack_drop();
    wait_idle();

    // reset in the middle of WAIT: outputs clear at once, result discarded
    mdl_delay = 10;
    exp_ack_q.push_back(3);
    set_req(3, 4'd2, 4'd2);
    wait_ack_drop();
    wait_init_low();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mul_init", 32'(mul_init), 32'd0);
    chk("midrst_mul_a", 32'(mul_a), 32'd0);
    chk("midrst_mul_b", 32'(mul_b), 32'd0);
    chk("midrst_rsp_pp", 32'(rsp_pp), 32'd0);
    chk("midrst_rsp_id", 32'(rsp_id), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mdl_delay = 3;
    repeat (20) @(negedge clk);
    expect_op(0, 8'd9, 1'b0, 0);
    set_req(0, 4'd1, 4'd9);
    wait_ack_drop();
    wait_idle();

    // operands changed after capture are ignored; id 1 waits for id 0 to finish
    expect_op(0, 8'd30, 1'b0, 0);
    expect_op(1, 8'd14, 1'b0, 0);
    set_req(0, 4'd5, 4'd6);
    wait_ack_drop();
    set_req(1, 4'd7, 4'd2);
    wait_init_low();
    req_a[3:0] = 4'hF;
    req_b[3:0] = 4'hF;
    wait_ack_drop();
    wait_idle();

    chk("ack_queue_empty", 32'(exp_ack_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
